// File: rtl/ebu75_checker.sv
// ebu75_checker: checks received EBU 75% colour bars pixel by pixel against
// the ideal bar values. It issues a good/bad verdict per active line and
// tracks lock with a SEARCH/LOCKED state machine.
//
// Optional feature: define EBU75_CHECKER_FIRSTERR_EN to capture the index of
// the first mismatching pixel of each evaluated line on first_err_x. Without
// the macro, first_err_x is tied to 511 and no capture register exists.
//
// Strobe semantics: newline and newpixel are single-cycle qualifiers sampled
// on the rising clock edge. There is no backpressure. A pixel is consumed
// only when visible_window && newpixel && !newline.
module ebu75_checker #(
  parameter int TOL        = 2,
  parameter int LOCK_LINES = 4,
  parameter int LOSS_LINES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newline,
  input  logic              newpixel,
  input  logic              visible_window,
  input  logic [7:0]        luma,
  input  logic signed [7:0] yuv_u,
  input  logic signed [7:0] yuv_v,
  output logic              line_done,
  output logic              line_ok,
  output logic              locked,
  output logic [15:0]       error_count,
  output logic [8:0]        first_err_x,
  output logic              dbg_state,
  output logic [3:0]        dbg_run
);

  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} lock_state_t;

  localparam logic [9:0] TOL_MAG  = 10'(TOL);
  localparam logic [3:0] LOCK_RUN = 4'(LOCK_LINES);
  localparam logic [3:0] LOSS_RUN = 4'(LOSS_LINES);

  lock_state_t       state, state_next;
  logic [3:0]        run, run_next;
  logic [8:0]        pix_idx;
  logic              compare_en;
  logic [7:0]        exp_y;
  logic signed [7:0] exp_u, exp_v;
  logic [9:0]        d_y, d_u, d_v;
  logic              pix_bad;
  logic              line_seen, line_bad;
  logic              line_eval;

  // Magnitude of a 10-bit two's complement difference (range is +-255).
  function automatic logic [9:0] mag(input logic [9:0] d);
    return d[9] ? (~d + 10'd1) : d;
  endfunction

  assign compare_en = visible_window && newpixel && !newline;
  assign line_eval  = newline && line_seen;

  // Pixel index: restarts on every newline and saturates at the last slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pix_idx <= 9'd0;
    else if (newline)
      pix_idx <= 9'd0;
    else if (visible_window && newpixel && (pix_idx != 9'd511))
      pix_idx <= pix_idx + 9'd1;
  end

  // Ideal bar value for the current index; past 255 only black is expected.
  always_comb begin
    exp_y = 8'd0;
    exp_u = 8'sd0;
    exp_v = 8'sd0;
    if (!pix_idx[8]) begin
      case (pix_idx[7:5])
        3'd0: begin exp_y = 8'd255; exp_u =  8'sd0;  exp_v =  8'sd0;  end
        3'd1: begin exp_y = 8'd168; exp_u = -8'sd41; exp_v =  8'sd9;  end
        3'd2: begin exp_y = 8'd133; exp_u =  8'sd14; exp_v = -8'sd58; end
        3'd3: begin exp_y = 8'd112; exp_u = -8'sd27; exp_v = -8'sd49; end
        3'd4: begin exp_y = 8'd76;  exp_u =  8'sd27; exp_v =  8'sd49; end
        3'd5: begin exp_y = 8'd56;  exp_u = -8'sd14; exp_v =  8'sd58; end
        3'd6: begin exp_y = 8'd20;  exp_u =  8'sd41; exp_v = -8'sd9;  end
        default: begin exp_y = 8'd0; exp_u = 8'sd0;  exp_v =  8'sd0;  end
      endcase
    end
  end

  // Differences are taken in 10 bits so no component comparison can wrap.
  assign d_y = {2'b00, luma} - {2'b00, exp_y};
  assign d_u = {{2{yuv_u[7]}}, yuv_u} - {{2{exp_u[7]}}, exp_u};
  assign d_v = {{2{yuv_v[7]}}, yuv_v} - {{2{exp_v[7]}}, exp_v};
  assign pix_bad = (mag(d_y) > TOL_MAG) || (mag(d_u) > TOL_MAG) ||
                   (mag(d_v) > TOL_MAG);

  // Saturating count of mismatching pixels across all lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      error_count <= 16'd0;
    else if (compare_en && pix_bad && (error_count != 16'hFFFF))
      error_count <= error_count + 16'd1;
  end

  // Per-line trackers: a line with no compared pixels yields no verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_seen <= 1'b0;
      line_bad  <= 1'b0;
    end else if (newline) begin
      line_seen <= 1'b0;
      line_bad  <= 1'b0;
    end else if (compare_en) begin
      line_seen <= 1'b1;
      if (pix_bad)
        line_bad <= 1'b1;
    end
  end

  // Verdict outputs: line_done pulses once, line_ok holds until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_done <= 1'b0;
      line_ok   <= 1'b0;
    end else begin
      line_done <= line_eval;
      if (line_eval)
        line_ok <= !line_bad;
    end
  end

`ifdef EBU75_CHECKER_FIRSTERR_EN
  logic [8:0] line_first;

  // Capture the first mismatching index; 511 marks a clean line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      line_first <= 9'd511;
    else if (newline)
      line_first <= 9'd511;
    else if (compare_en && pix_bad && !line_bad)
      line_first <= pix_idx;
  end

  // Publish the captured index together with the line verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      first_err_x <= 9'd511;
    else if (line_eval)
      first_err_x <= line_first;
  end
`else
  assign first_err_x = 9'd511;
`endif

  // Lock FSM state register, including the shared run counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_SEARCH;
      run   <= 4'd0;
    end else begin
      state <= state_next;
      run   <= run_next;
    end
  end

  // Lock FSM next state: advance on each verdict; run clears on transitions.
  always_comb begin
    state_next = state;
    run_next   = run;
    if (line_eval) begin
      case (state)
        ST_SEARCH: begin
          if (line_bad)
            run_next = 4'd0;
          else if (run + 4'd1 >= LOCK_RUN) begin
            state_next = ST_LOCKED;
            run_next   = 4'd0;
          end else
            run_next = run + 4'd1;
        end
        default: begin
          if (!line_bad)
            run_next = 4'd0;
          else if (run + 4'd1 >= LOSS_RUN) begin
            state_next = ST_SEARCH;
            run_next   = 4'd0;
          end else
            run_next = run + 4'd1;
        end
      endcase
    end
  end

  // Lock FSM outputs, including the state and run debug view.
  always_comb begin
    locked    = (state == ST_LOCKED);
    dbg_state = state;
    dbg_run   = run;
  end

endmodule

// File: tb/tb_ebu75_checker.sv
// tb_ebu75_checker: randomized and directed stimulus for ebu75_checker. The
// outputs are compared every cycle against a behavioural model of the
// colour-bar rules, and literal expectations pin the model.
// Honours EBU75_CHECKER_FIRSTERR_EN the same way as the design.
module tb_ebu75_checker;

  localparam int TOL        = 2;
  localparam int LOCK_LINES = 4;
  localparam int LOSS_LINES = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              newline = 1'b0;
  logic              newpixel = 1'b0;
  logic              visible_window = 1'b0;
  logic [7:0]        luma = 8'd0;
  logic signed [7:0] yuv_u = 8'sd0;
  logic signed [7:0] yuv_v = 8'sd0;
  logic              line_done, line_ok, locked, dbg_state;
  logic [15:0]       error_count;
  logic [8:0]        first_err_x;
  logic [3:0]        dbg_run;

  ebu75_checker #(.TOL(TOL), .LOCK_LINES(LOCK_LINES), .LOSS_LINES(LOSS_LINES)) dut (
    .clk(clk), .rst(rst), .newline(newline), .newpixel(newpixel),
    .visible_window(visible_window), .luma(luma), .yuv_u(yuv_u), .yuv_v(yuv_v),
    .line_done(line_done), .line_ok(line_ok), .locked(locked),
    .error_count(error_count), .first_err_x(first_err_x),
    .dbg_state(dbg_state), .dbg_run(dbg_run)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  bit run_cmp  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int bar_y[8] = '{255, 168, 133, 112, 76, 56, 20, 0};
  int bar_u[8] = '{0, -41, 14, -27, 27, -14, 41, 0};
  int bar_v[8] = '{0, 9, -58, -49, 49, 58, -9, 0};

  function automatic int ideal(input int idx, input int comp);
    if (idx >= 256) return 0;
    case (comp)
      0: return bar_y[idx / 32];
      1: return bar_u[idx / 32];
      default: return bar_v[idx / 32];
    endcase
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic bit pixel_bad(input int idx, input int y, input int u, input int v);
    return (iabs(y - ideal(idx, 0)) > TOL) || (iabs(u - ideal(idx, 1)) > TOL) ||
           (iabs(v - ideal(idx, 2)) > TOL);
  endfunction

  int m_idx, m_first, m_first_out, m_run, m_err;
  bit m_seen, m_bad, m_done, m_ok, m_locked, m_pb;

  // Model of the registered outputs as they stand after each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx = 0; m_seen = 0; m_bad = 0; m_first = 511; m_first_out = 511;
      m_done = 0; m_ok = 0; m_locked = 0; m_run = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (newline) begin
        if (m_seen) begin
          m_done = 1;
          m_ok   = !m_bad;
`ifdef EBU75_CHECKER_FIRSTERR_EN
          m_first_out = m_bad ? m_first : 511;
`endif
          if (m_locked) begin
            if (m_ok) m_run = 0;
            else begin
              m_run++;
              if (m_run == LOSS_LINES) begin m_locked = 0; m_run = 0; end
            end
          end else begin
            if (!m_ok) m_run = 0;
            else begin
              m_run++;
              if (m_run == LOCK_LINES) begin m_locked = 1; m_run = 0; end
            end
          end
        end
        m_seen = 0; m_bad = 0; m_first = 511; m_idx = 0;
      end else if (visible_window && newpixel) begin
        m_pb = pixel_bad(m_idx, int'(luma), int'(yuv_u), int'(yuv_v));
        m_seen = 1;
        if (m_pb) begin
          if (!m_bad) m_first = m_idx;
          m_bad = 1;
          if (m_err < 65535) m_err++;
        end
        if (m_idx < 511) m_idx++;
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_cmp) begin
      check("line_done", line_done, m_done);
      check("line_ok", line_ok, m_ok);
      check("locked", locked, m_locked);
      check("error_count", error_count, m_err);
      check("first_err_x", first_err_x, m_first_out);
      check("dbg_run", dbg_run, m_run);
      check("dbg_state", dbg_state, m_locked);
      if (line_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit nl, input bit vw, input bit np, input int y, input int u, input int v);
    @(negedge clk);
    newline = nl; visible_window = vw; newpixel = np;
    luma = 8'(y); yuv_u = 8'(u); yuv_v = 8'(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Newline followed by n exact pixels; pixel bad_idx carries bad_luma instead.
  task automatic exact_line(input int n, input int bad_idx, input int bad_luma);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++)
      cyc(0, 1, 1, (i == bad_idx) ? bad_luma : ideal(i, 0), ideal(i, 1), ideal(i, 2));
    idle(2);
  endtask

  task automatic flush();
    cyc(1, 0, 0, 0, 0, 0);
    idle(3);
  endtask

  function automatic int clampi(input int a, input int lo, input int hi);
    return (a < lo) ? lo : (a > hi) ? hi : a;
  endfunction

  function automatic int rdev(input int r);
    return int'($urandom_range(0, 2 * r)) - r;
  endfunction

  // Randomized line: gaps, non-visible strobes, near-TOL noise, bad pixels.
  task automatic random_line();
    int n, k, dy, du, dv;
    bit dirty;
    n = $urandom_range(0, 300);
    dirty = $urandom_range(0, 1);
    if ($urandom_range(0, 7) == 0) cyc(1, 1, 1, 0, 100, 0);
    else cyc(1, 0, 0, 0, 0, 0);
    k = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 5) == 0) cyc(0, 1, 0, 0, 0, 0);
      if ($urandom_range(0, 9) == 0) cyc(0, 0, 1, 0, 0, 0);
      if (dirty && ($urandom_range(0, 49) == 0)) begin
        dy = rdev(6); du = rdev(6); dv = rdev(6);
      end else begin
        dy = rdev(TOL); du = rdev(TOL); dv = rdev(TOL);
      end
      cyc(0, 1, 1, clampi(ideal(k, 0) + dy, 0, 255),
          clampi(ideal(k, 1) + du, -128, 127), clampi(ideal(k, 2) + dv, -128, 127));
      if (k < 511) k++;
    end
    idle($urandom_range(0, 3));
  endtask

  // ---------------- main sequence ----------------
  int d0, e0, exp_first;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_cmp = 1'b1;
    @(negedge clk);
    check("reset_locked", locked, 0);
    check("reset_line_ok", line_ok, 0);
    check("reset_err", error_count, 0);
    check("reset_first", first_err_x, 511);

    // six exact lines of 320 visible pixels
    d0 = done_cnt;
    for (int l = 0; l < 6; l++) exact_line(320, -1, 0);
    flush();
    check("bars_done6", done_cnt - d0, 6);
    check("bars_locked", locked, 1);
    check("bars_model_locked", m_locked, 1);
    check("bars_err", error_count, 0);

    // one bad pixel at index 100 while locked
`ifdef EBU75_CHECKER_FIRSTERR_EN
    exp_first = 100;
`else
    exp_first = 511;
`endif
    exact_line(320, 100, 140);
    flush();
    check("px100_err", error_count, 1);
    check("px100_line_ok", line_ok, 0);
    check("px100_first", first_err_x, exp_first);
    check("px100_locked", locked, 1);

    // good line, then two bad lines drop lock, then one good line
    exact_line(320, -1, 0);
    exact_line(320, 10, 0);
    exact_line(320, 10, 0);
    flush();
    check("loss_locked", locked, 0);
    exact_line(320, -1, 0);
    flush();
    check("loss_good_locked", locked, 0);
    check("loss_good_run", dbg_run, 1);

    // deviation exactly TOL, then TOL+1, on bar 1
    e0 = error_count;
    exact_line(64, 40, 170);
    flush();
    check("tol_edge_err", error_count, e0);
    exact_line(64, 40, 171);
    flush();
    check("tol_plus1_err", error_count, e0 + 1);

    // past index 256 only black is accepted
    exact_line(320, 300, 5);
    flush();
    check("px300_err", error_count, e0 + 2);
    check("px300_line_ok", line_ok, 0);

    // newline coincident with a visible bad pixel: that pixel is ignored
    e0 = error_count;
    cyc(1, 1, 1, 0, 100, 0);
    for (int i = 0; i < 64; i++) cyc(0, 1, 1, ideal(i, 0), ideal(i, 1), ideal(i, 2));
    flush();
    check("coincident_err", error_count, e0);
    check("coincident_line_ok", line_ok, 1);

    // randomized lines
    for (int l = 0; l < 30; l++) random_line();
    flush();

    // three good lines then an asynchronous reset mid-line
    for (int l = 0; l < 3; l++) exact_line(320, -1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) cyc(0, 1, 1, ideal(i, 0), 100, ideal(i, 2));
    #2 rst = 1'b1;
    #1;
    check("arst_line_done", line_done, 0);
    check("arst_line_ok", line_ok, 0);
    check("arst_locked", locked, 0);
    check("arst_err", error_count, 0);
    check("arst_first", first_err_x, 511);
    check("arst_run", dbg_run, 0);
    @(negedge clk);
    rst = 1'b0;
    newline = 0; visible_window = 0; newpixel = 0;
    d0 = done_cnt;
    flush();
    check("arst_blank_done", done_cnt - d0, 0);

    // saturation: one long line where every pixel is bad
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) cyc(0, 1, 1, 0, 100, 0);
    idle(2);
    check("sat_err", error_count, 65535);
    flush();
    check("sat_hold", error_count, 65535);

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
